// File: rtl/rv32i_immediate_generator.sv
// rtl/rv32i_immediate_generator.sv - RV32I immediate decode with registered sign-extended output
module rv32i_immediate_generator (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic        imm_valid,
    output logic [2:0]  imm_type,
    output logic        imm_illegal
);

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_sign;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm;
    logic [2:0]  w_type;
    logic        w_illegal;

    logic [31:0] r_imm;
    logic        r_imm_valid;
    logic [2:0]  r_imm_type;
    logic        r_imm_illegal;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_sign   = instr[31];

    assign w_imm_i = {{20{w_sign}}, instr[31:20]};
    assign w_imm_s = {{20{w_sign}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{w_sign}}, w_sign, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_sign}}, w_sign, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        w_imm     = 32'd0;
        w_type    = TYPE_NONE;
        w_illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OP_OP: begin
                    w_imm  = 32'd0;
                    w_type = TYPE_NONE;
                end
                OP_OP_IMM: begin
                    w_type = TYPE_I;
                    // Shift-immediates carry only a 5-bit shamt; funct7 bits are not part of the value.
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                        w_imm = {27'b0, instr[24:20]};
                    else
                        w_imm = w_imm_i;
                end
                OP_LOAD, OP_JALR, OP_MISC_MEM, OP_SYSTEM: begin
                    w_imm  = w_imm_i;
                    w_type = TYPE_I;
                end
                OP_STORE: begin
                    w_imm  = w_imm_s;
                    w_type = TYPE_S;
                end
                OP_BRANCH: begin
                    w_imm  = w_imm_b;
                    w_type = TYPE_B;
                end
                OP_LUI, OP_AUIPC: begin
                    w_imm  = w_imm_u;
                    w_type = TYPE_U;
                end
                OP_JAL: begin
                    w_imm  = w_imm_j;
                    w_type = TYPE_J;
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    // Payload holds while instr_valid is low so consumers see the last decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm         <= 32'd0;
            r_imm_valid   <= 1'b0;
            r_imm_type    <= TYPE_NONE;
            r_imm_illegal <= 1'b0;
        end else begin
            r_imm_valid <= instr_valid;
            if (instr_valid) begin
                r_imm         <= w_imm;
                r_imm_type    <= w_type;
                r_imm_illegal <= w_illegal;
            end
        end
    end

    assign imm         = r_imm;
    assign imm_valid   = r_imm_valid;
    assign imm_type    = r_imm_type;
    assign imm_illegal = r_imm_illegal;

endmodule

// File: tb/tb_rv32i_immediate_generator.sv
// tb/tb_rv32i_immediate_generator.sv - directed self-checking bench for rv32i_immediate_generator
module tb_rv32i_immediate_generator;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        imm_valid;
    logic [2:0]  imm_type;
    logic        imm_illegal;

    int n_vec;
    int n_err;

    rv32i_immediate_generator dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .imm         (imm),
        .imm_valid   (imm_valid),
        .imm_type    (imm_type),
        .imm_illegal (imm_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs just after an edge, then sample 1 time unit after the following edge.
    task automatic drive_and_step(input logic r, input logic v, input logic [31:0] w);
        rst         = r;
        instr_valid = v;
        instr       = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive_and_step(1'b1, 1'b1, 32'h00410193);
        drive_and_step(1'b1, 1'b1, 32'h00410193);
        n_vec++;
        if (imm !== 32'd0 || imm_valid !== 1'b0 || imm_type !== 3'd0 || imm_illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset: imm=%h valid=%b type=%0d illegal=%b, need 0/0/0/0",
                     imm, imm_valid, imm_type, imm_illegal);
        end
    endtask

    task automatic test_stream;
        logic [31:0] v_in  [6] = '{32'h003100B3, 32'h00410193, 32'h0041A623,
                                   32'h0041D663, 32'h050001EF, 32'h00002537};
        logic [31:0] v_imm [6] = '{32'd0, 32'd4, 32'd12, 32'd12, 32'd80, 32'h00002000};
        logic [2:0]  v_typ [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4};
        for (int i = 0; i < 6; i++) begin
            drive_and_step(1'b0, 1'b1, v_in[i]);
            n_vec++;
            if (imm !== v_imm[i] || imm_type !== v_typ[i] || imm_valid !== 1'b1 || imm_illegal !== 1'b0) begin
                n_err++;
                $display("FAIL stream[%0d] instr=%h: imm=%h type=%0d valid=%b illegal=%b, need imm=%h type=%0d valid=1 illegal=0",
                         i, v_in[i], imm, imm_type, imm_valid, imm_illegal, v_imm[i], v_typ[i]);
            end
        end
    endtask

    task automatic test_sign_extension;
        logic [31:0] v_in  [3] = '{32'hFFF00093, 32'hFE000FE3, 32'hFFDFF06F};
        logic [31:0] v_imm [3] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFC};
        logic [2:0]  v_typ [3] = '{3'd1, 3'd3, 3'd5};
        for (int i = 0; i < 3; i++) begin
            drive_and_step(1'b0, 1'b1, v_in[i]);
            n_vec++;
            if (imm !== v_imm[i] || imm_type !== v_typ[i] || imm_illegal !== 1'b0) begin
                n_err++;
                $display("FAIL sign_ext[%0d] instr=%h: imm=%h type=%0d illegal=%b, need imm=%h type=%0d illegal=0",
                         i, v_in[i], imm, imm_type, imm_illegal, v_imm[i], v_typ[i]);
            end
        end
    endtask

    task automatic test_shift_imm;
        drive_and_step(1'b0, 1'b1, 32'h4030D093);
        n_vec++;
        if (imm !== 32'd3 || imm_type !== 3'd1 || imm_illegal !== 1'b0) begin
            n_err++;
            $display("FAIL srai: imm=%h type=%0d illegal=%b, need imm=00000003 type=1 illegal=0",
                     imm, imm_type, imm_illegal);
        end
        drive_and_step(1'b0, 1'b1, 32'h00309093);
        n_vec++;
        if (imm !== 32'd3 || imm_type !== 3'd1) begin
            n_err++;
            $display("FAIL slli: imm=%h type=%0d, need imm=00000003 type=1", imm, imm_type);
        end
    endtask

    task automatic test_illegal;
        drive_and_step(1'b0, 1'b1, 32'hFFF00093);
        drive_and_step(1'b0, 1'b1, 32'h0000007F);
        n_vec++;
        if (imm !== 32'd0 || imm_type !== 3'd0 || imm_illegal !== 1'b1 || imm_valid !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_7f: imm=%h type=%0d illegal=%b valid=%b, need 0/0/1/1",
                     imm, imm_type, imm_illegal, imm_valid);
        end
        drive_and_step(1'b0, 1'b1, 32'h00410193);
        drive_and_step(1'b0, 1'b1, 32'h00000000);
        n_vec++;
        if (imm !== 32'd0 || imm_type !== 3'd0 || imm_illegal !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_zero: imm=%h type=%0d illegal=%b, need 0/0/1",
                     imm, imm_type, imm_illegal);
        end
        drive_and_step(1'b0, 1'b1, 32'h0000100F);
        n_vec++;
        if (imm_illegal !== 1'b0 || imm_type !== 3'd1 || imm !== 32'd0) begin
            n_err++;
            $display("FAIL fence_i: imm=%h type=%0d illegal=%b, need 0/1/0", imm, imm_type, imm_illegal);
        end
    endtask

    task automatic test_valid_toggle;
        drive_and_step(1'b0, 1'b1, 32'h00410193);
        drive_and_step(1'b0, 1'b0, 32'hFFF00093);
        n_vec++;
        if (imm_valid !== 1'b0 || imm !== 32'd4 || imm_type !== 3'd1 || imm_illegal !== 1'b0) begin
            n_err++;
            $display("FAIL valid_drop: valid=%b imm=%h type=%0d illegal=%b, need 0/00000004/1/0",
                     imm_valid, imm, imm_type, imm_illegal);
        end
        drive_and_step(1'b0, 1'b0, 32'h0000007F);
        n_vec++;
        if (imm_valid !== 1'b0 || imm !== 32'd4 || imm_illegal !== 1'b0) begin
            n_err++;
            $display("FAIL valid_hold: valid=%b imm=%h illegal=%b, need 0/00000004/0",
                     imm_valid, imm, imm_illegal);
        end
        drive_and_step(1'b0, 1'b1, 32'h0041A623);
        n_vec++;
        if (imm_valid !== 1'b1 || imm !== 32'd12 || imm_type !== 3'd2) begin
            n_err++;
            $display("FAIL valid_resume: valid=%b imm=%h type=%0d, need 1/0000000c/2",
                     imm_valid, imm, imm_type);
        end
    endtask

    task automatic test_mid_reset;
        drive_and_step(1'b0, 1'b1, 32'hFFDFF06F);
        drive_and_step(1'b1, 1'b1, 32'h00002537);
        n_vec++;
        if (imm !== 32'd0 || imm_valid !== 1'b0 || imm_type !== 3'd0 || imm_illegal !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: imm=%h valid=%b type=%0d illegal=%b, need 0/0/0/0",
                     imm, imm_valid, imm_type, imm_illegal);
        end
        drive_and_step(1'b0, 1'b0, 32'h00002537);
        n_vec++;
        if (imm_valid !== 1'b0 || imm !== 32'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: valid=%b imm=%h, need 0/00000000", imm_valid, imm);
        end
        drive_and_step(1'b0, 1'b1, 32'h00002537);
        n_vec++;
        if (imm_valid !== 1'b1 || imm !== 32'h00002000 || imm_type !== 3'd4) begin
            n_err++;
            $display("FAIL post_reset_first: valid=%b imm=%h type=%0d, need 1/00002000/4",
                     imm_valid, imm, imm_type);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        @(posedge clk);
        #1;
        test_reset;
        test_stream;
        test_sign_extension;
        test_shift_imm;
        test_illegal;
        test_valid_toggle;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
